syscall_unit: RTL and testbench

SYSCALL_UNIT -- requirements
Module: syscall_unit

---
 rtl/syscall_unit.sv | 209 ++++++++++++++++++++
 tb/tb_syscall_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// System-call service unit: prints characters, signed decimals and hex words
// as a stream of ASCII characters, stalls the pipeline while a service is in
// flight, and latches the exit service as a permanent halt.
module syscall_unit #(
    parameter int HEX_PREFIX = 1,
    parameter int UPPER_HEX  = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param1,
    output logic        stall_req,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic        bad_funct
);

    localparam logic [31:0] FN_INT  = 32'd1;
    localparam logic [31:0] FN_EXIT = 32'd10;
    localparam logic [31:0] FN_CHAR = 32'd11;
    localparam logic [31:0] FN_HEX  = 32'd34;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_EMIT,
        S_DONE,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Captured request and conversion working state
    logic [31:0] r_funct;
    logic [31:0] r_mag;
    logic        r_neg;
    logic [1:0]  r_phase;
    logic [2:0]  r_cnt;

    // Character buffer, filled last-character-first and drained from the top
    logic [7:0]  r_buf [0:10];
    logic [3:0]  r_len;
    logic [3:0]  r_idx;

    logic        r_out_valid;
    logic [7:0]  r_out_data;

    logic        w_accept;
    logic        w_supported;
    logic        w_neg_in;
    logic        w_conv_last;
    logic        w_emit_last;
    logic [31:0] w_quot;
    logic [3:0]  w_rem;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'd48 + {4'd0, nib};
        else if (UPPER_HEX != 0)
            return 8'd55 + {4'd0, nib};
        else
            return 8'd87 + {4'd0, nib};
    endfunction

    assign w_accept    = (r_state == S_IDLE) && syscall_valid;
    assign w_supported = (syscall_funct == FN_INT) || (syscall_funct == FN_CHAR) ||
                         (syscall_funct == FN_HEX);
    assign w_neg_in    = (syscall_funct == FN_INT) && syscall_param1[31];

    // One decimal digit per cycle: remainder is the next digit, quotient carries on
    assign w_quot = r_mag / 32'd10;
    assign w_rem  = 4'(r_mag - (w_quot * 32'd10));

    // Final CONV step: char is immediate, decimal ends after the sign slot,
    // hex ends after the prefix slots (or right after the nibbles without one)
    assign w_conv_last = (r_state == S_CONV) &&
                         (((r_funct == FN_CHAR) && (r_phase == 2'd0)) ||
                          ((r_funct == FN_INT)  && (r_phase == 2'd1)) ||
                          ((r_funct == FN_HEX)  &&
                           (r_phase == ((HEX_PREFIX != 0) ? 2'd2 : 2'd1))));

    assign w_emit_last = (r_state == S_EMIT) && r_out_valid && out_ready && (r_idx == 4'd0);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (syscall_valid) begin
                    if (syscall_funct == FN_EXIT)
                        w_next = S_HALT;
                    else if (w_supported)
                        w_next = S_CONV;
                    else
                        w_next = S_DONE;
                end
            end
            S_CONV:  if (w_conv_last) w_next = S_EMIT;
            S_EMIT:  if (w_emit_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, string building and character hand-off
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_funct     <= '0;
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_phase     <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < 11; i++)
                r_buf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (syscall_valid) begin
                        r_funct     <= syscall_funct;
                        r_neg       <= w_neg_in;
                        r_mag       <= w_neg_in ? (~syscall_param1 + 32'd1) : syscall_param1;
                        r_phase     <= '0;
                        r_cnt       <= '0;
                        r_len       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                S_CONV: begin
                    case (r_phase)
                        2'd0: begin
                            if (r_funct == FN_CHAR) begin
                                r_buf[0] <= r_mag[7:0];
                                r_len    <= 4'd1;
                            end else if (r_funct == FN_INT) begin
                                r_buf[r_len] <= 8'd48 + {4'd0, w_rem};
                                r_len        <= r_len + 4'd1;
                                r_mag        <= w_quot;
                                if (w_quot == 32'd0)
                                    r_phase <= 2'd1;
                            end else begin
                                r_buf[r_len] <= hex_char(r_mag[3:0]);
                                r_len        <= r_len + 4'd1;
                                r_mag        <= r_mag >> 4;
                                r_cnt        <= r_cnt + 3'd1;
                                if (r_cnt == 3'd7)
                                    r_phase <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if ((r_funct == FN_INT) && r_neg) begin
                                r_buf[r_len] <= 8'h2D;
                                r_len        <= r_len + 4'd1;
                            end else if ((r_funct == FN_HEX) && (HEX_PREFIX != 0)) begin
                                r_buf[r_len] <= 8'h78;
                                r_len        <= r_len + 4'd1;
                            end
                            r_phase <= 2'd2;
                        end
                        default: begin
                            r_buf[r_len] <= 8'h30;
                            r_len        <= r_len + 4'd1;
                        end
                    endcase
                end
                S_EMIT: begin
                    if (!r_out_valid) begin
                        r_out_data  <= r_buf[r_len - 4'd1];
                        r_idx       <= r_len - 4'd1;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (r_idx == 4'd0) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_data <= r_buf[r_idx - 4'd1];
                            r_idx      <= r_idx - 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_req = reset_n && ((r_state == S_HALT) ||
                                   (syscall_valid && (r_state != S_DONE)));
    assign bad_funct = reset_n && w_accept && (syscall_funct != FN_EXIT) && !w_supported;
    assign halted    = (r_state == S_HALT);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: character, decimal and hex printing,
// consumer back-pressure, unsupported codes, exit/halt and mid-string reset.
module tb_syscall_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        syscall_valid;
    logic [31:0] syscall_funct;
    logic [31:0] syscall_param1;
    logic        stall_req;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        halted;
    logic        bad_funct;

    int vectors    = 0;
    int miscompares = 0;

    syscall_unit #(.HEX_PREFIX(1), .UPPER_HEX(0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .syscall_valid  (syscall_valid),
        .syscall_funct  (syscall_funct),
        .syscall_param1 (syscall_param1),
        .stall_req      (stall_req),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .halted         (halted),
        .bad_funct      (bad_funct)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request from a negedge and collect transferred characters until
    // the unit drops stall_req (DONE). Optionally holds out_ready low on one character.
    task automatic do_call(input logic [31:0] f, input logic [31:0] p,
                           input int hold_at, input int hold_len,
                           output logic [127:0] acc, output int nchars,
                           output int first_vld, output bit stable_ok,
                           output bit timeout);
        int hold;
        logic [7:0] held;
        acc = '0; nchars = 0; first_vld = -1; stable_ok = 1'b1; timeout = 1'b1;
        hold = 0; held = '0;
        syscall_valid = 1'b1; syscall_funct = f; syscall_param1 = p; out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0 && !stall_req) begin
                timeout = 1'b0;
                break;
            end
            if (out_valid && first_vld < 0) first_vld = c;
            if (hold_at >= 0 && nchars == hold_at && out_valid && hold < hold_len) begin
                out_ready = 1'b0;
                if (hold == 0) held = out_data;
                else if (out_data !== held) stable_ok = 1'b0;
                hold++;
            end else begin
                if (hold > 0 && nchars == hold_at && out_data !== held) stable_ok = 1'b0;
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                acc = {acc[119:0], out_data};
                nchars++;
            end
            @(negedge clock);
        end
        syscall_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; syscall_valid = 1'b1; syscall_funct = 32'd11;
        syscall_param1 = 32'h41; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (bad_funct !== 1'b0) begin miscompares++; $display("FAIL reset_bad_funct: got %b want 0", bad_funct); end
        syscall_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL idle_stall: got %b want 0", stall_req); end
    endtask

    task automatic test_print_char();
        logic [127:0] acc; int n, fv; bit st, to;
        do_call(32'd11, 32'h0000_0041, -1, 0, acc, n, fv, st, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL char_done: timeout got %b want 0", to); end
        vectors++; if (acc !== 128'h41) begin miscompares++; $display("FAIL char_data: got %h want 41", acc); end
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL char_count: got %0d want 1", n); end
        @(negedge clock);
        vectors++; if (stall_req !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL char_idle: stall %b valid %b want 0 0", stall_req, out_valid);
        end
    endtask

    task automatic test_print_int();
        logic [127:0] acc; int n, fv; bit st, to;
        logic [31:0]  params [4];
        logic [127:0] exps [4];
        int           lens [4];
        params[0] = 32'hFFFF_FECF; exps[0] = "-305";        lens[0] = 4;
        params[1] = 32'h0000_0000; exps[1] = "0";           lens[1] = 1;
        params[2] = 32'h8000_0000; exps[2] = "-2147483648"; lens[2] = 11;
        params[3] = 32'h7FFF_FFFF; exps[3] = "2147483647";  lens[3] = 10;
        for (int i = 0; i < 4; i++) begin
            do_call(32'd1, params[i], -1, 0, acc, n, fv, st, to);
            vectors++; if (acc !== exps[i] || to !== 1'b0) begin
                miscompares++; $display("FAIL int_string[%0d]: got \"%s\" want \"%s\" (timeout %b)", i, acc, exps[i], to);
            end
            vectors++; if (n !== lens[i]) begin miscompares++; $display("FAIL int_count[%0d]: got %0d want %0d", i, n, lens[i]); end
            if (i == 2) begin
                vectors++; if (fv < 1 || fv > 40) begin miscompares++; $display("FAIL int_latency: first out_valid at %0d want 1..40", fv); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_print_hex();
        logic [127:0] acc; int n, fv; bit st, to;
        do_call(32'd34, 32'hDEAD_BEEF, 2, 5, acc, n, fv, st, to);
        vectors++; if (acc !== "0xdeadbeef" || to !== 1'b0) begin
            miscompares++; $display("FAIL hex_string: got \"%s\" want \"0xdeadbeef\" (timeout %b)", acc, to);
        end
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL hex_count: got %0d want 10", n); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL hex_stable: got %b want 1", st); end
        @(negedge clock);
    endtask

    task automatic test_bad_funct();
        syscall_valid = 1'b1; syscall_funct = 32'd7; syscall_param1 = 32'h1234; out_ready = 1'b1;
        #1;
        vectors++; if (bad_funct !== 1'b1) begin miscompares++; $display("FAIL bad_pulse: got %b want 1", bad_funct); end
        @(negedge clock);
        vectors++; if (bad_funct !== 1'b0) begin miscompares++; $display("FAIL bad_pulse_end: got %b want 0", bad_funct); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL bad_stall: got %b want 0", stall_req); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bad_output: got %b want 0", out_valid); end
        syscall_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [127:0] acc; int n, fv; bit st, to;
        do_call(32'd11, 32'h0000_0048, -1, 0, acc, n, fv, st, to);
        vectors++; if (acc !== 128'h48 || to !== 1'b0) begin miscompares++; $display("FAIL b2b_first: got %h want 48 (timeout %b)", acc, to); end
        do_call(32'd11, 32'h0000_0069, -1, 0, acc, n, fv, st, to);
        vectors++; if (acc !== 128'h69 || to !== 1'b0) begin miscompares++; $display("FAIL b2b_second: got %h want 69 (timeout %b)", acc, to); end
        @(negedge clock);
    endtask

    task automatic test_reset_midstring();
        logic [127:0] acc; int n, fv; bit st, to;
        int got; bit hit;
        got = 0; hit = 1'b0;
        syscall_valid = 1'b1; syscall_funct = 32'd1; syscall_param1 = 32'hFFFF_FECF; out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && got == 1) begin
                hit = 1'b1;
                break;
            end
            if (out_valid) got++;
            @(negedge clock);
        end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL rst_mid_reach: got %b want 1", hit); end
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall: got %b want 0", stall_req); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        do_call(32'd1, 32'hFFFF_FECF, -1, 0, acc, n, fv, st, to);
        vectors++; if (acc !== "-305" || n !== 4 || to !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_restart: got \"%s\" (%0d chars) want \"-305\" (4 chars)", acc, n);
        end
        @(negedge clock);
    endtask

    task automatic test_halt();
        int bad; int seen;
        bad = 0; seen = 0;
        syscall_valid = 1'b1; syscall_funct = 32'd10; syscall_param1 = 32'h0; out_ready = 1'b1;
        @(negedge clock);
        for (int c = 0; c < 100; c++) begin
            if (halted !== 1'b1 || stall_req !== 1'b1 || out_valid !== 1'b0) bad++;
            @(negedge clock);
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL halt_hold: %0d bad cycles want 0", bad); end
        syscall_valid = 1'b0;
        @(negedge clock);
        syscall_valid = 1'b1; syscall_funct = 32'd11; syscall_param1 = 32'h5A;
        for (int c = 0; c < 50; c++) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clock);
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL halt_ignore: %0d output cycles want 0", seen); end
        vectors++; if (halted !== 1'b1 || stall_req !== 1'b1) begin
            miscompares++; $display("FAIL halt_absorb: halted %b stall %b want 1 1", halted, stall_req);
        end
        syscall_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_cleared: got %b want 0", halted); end
    endtask

    initial begin
        reset_n = 1'b0; syscall_valid = 1'b0; syscall_funct = '0;
        syscall_param1 = '0; out_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_print_char();
        test_print_int();
        test_print_hex();
        test_bad_funct();
        test_back_to_back();
        test_reset_midstring();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
